// File: rtl/cbus_ram_responder_if.sv
// Cache-bus request/response bundle between a cbus initiator and a memory-side responder.
interface cbus_ram_responder_if;
  // request
  logic        valid;
  logic        is_write;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [3:0]  strobe;
  logic [31:0] wdata;
  logic [3:0]  len;
  // response
  logic        ready;
  logic        last;
  logic [31:0] rdata;

  modport master (
    output valid, is_write, size, addr, strobe, wdata, len,
    input  ready, last, rdata
  );

  modport slave (
    input  valid, is_write, size, addr, strobe, wdata, len,
    output ready, last, rdata
  );
endinterface

// File: rtl/cbus_ram_responder.sv
// Memory-side cbus responder: word-addressed RAM serving incrementing bursts of len+1 beats
// after a programmable first-beat latency, with byte-strobed writes.
module cbus_ram_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset_,
  cbus_ram_responder_if.slave   cbus,
  output logic [31:0]           mem [2**DEPTH_LOG2]
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, BURST, REST} state_t;

  state_t                 state, state_nxt;
  logic [DEPTH_LOG2-1:0]  idx, idx_nxt;
  logic [3:0]             len_q, len_nxt;
  logic [3:0]             beat, beat_nxt;
  logic                   wr_q, wr_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   ready, last, we;

  // size and the address bits outside the word index do not affect addressing
  logic unused_bits;
  assign unused_bits = ^{cbus.size, cbus.addr[31:DEPTH_LOG2+2], cbus.addr[1:0]};

  assign ready = (state == BURST);
  assign last  = ready && (beat == len_q);
  // a beat whose valid has already dropped is an abort and must not touch the RAM
  assign we    = ready && wr_q && cbus.valid;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state <= IDLE;
      idx   <= '0;
      len_q <= '0;
      beat  <= '0;
      wr_q  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      len_q <= len_nxt;
      beat  <= beat_nxt;
      wr_q  <= wr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    len_nxt   = len_q;
    beat_nxt  = beat;
    wr_nxt    = wr_q;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (cbus.valid) begin
          idx_nxt  = cbus.addr[DEPTH_LOG2+1:2];
          len_nxt  = cbus.len;
          wr_nxt   = cbus.is_write;
          beat_nxt = '0;
          if (LATENCY == 0) begin
            state_nxt = BURST;
          end else begin
            // WAIT spans LATENCY cycles, so the counter starts one below it
            state_nxt = WAIT;
            cnt_nxt   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (!cbus.valid)      state_nxt = IDLE;
        else if (cnt == '0)   state_nxt = BURST;
        else                  cnt_nxt   = cnt - 1'b1;
      end
      BURST: begin
        if (!cbus.valid) begin
          state_nxt = IDLE;
        end else if (last) begin
          state_nxt = REST;
        end else begin
          beat_nxt = beat + 1'b1;
          idx_nxt  = idx + 1'b1;
        end
      end
      REST:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (cbus.strobe[i]) mem[idx][8*i +: 8] <= cbus.wdata[8*i +: 8];
      end
    end
  end

  assign cbus.ready = ready;
  assign cbus.last  = last;
  assign cbus.rdata = (ready && !wr_q) ? mem[idx] : 32'h0;

endmodule
